// File: rtl/bird_physics.sv
// Bird vertical physics and game-state FSM (IDLE/FLY/DEAD), updated once per frame_tick.
// Optional macro CEILING_KILL_EN: hitting the ceiling kills the bird instead of clamping.
module bird_physics #(
    parameter int unsigned Y_W       = 10,
    parameter int unsigned V_W       = 8,
    parameter int unsigned Y_START   = 240,
    parameter int unsigned Y_MAX     = 464,
    parameter int unsigned GRAVITY   = 1,
    parameter int unsigned FLAP_VEL  = 8,
    parameter int unsigned MAX_FALL  = 10,
    parameter int unsigned DEAD_HOLD = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flap_btn_i,
    input  logic                  frame_tick_i,
    output logic [Y_W-1:0]        bird_y_o,
    output logic signed [V_W-1:0] bird_vel_o,
    output logic [1:0]            state_o,
    output logic                  alive_o,
    output logic                  flap_ack_o
);

    localparam int unsigned SW = Y_W + 2;
    localparam int unsigned HW = $clog2(DEAD_HOLD + 1);

    localparam logic [Y_W-1:0]        YStart     = Y_W'(Y_START);
    localparam logic [Y_W-1:0]        YStartFlap = Y_W'(Y_START - FLAP_VEL);
    localparam logic [Y_W-1:0]        YMaxY      = Y_W'(Y_MAX);
    localparam logic signed [SW-1:0]  YMaxS      = SW'(Y_MAX);
    localparam logic signed [V_W-1:0] VelFlap    = -(V_W'(FLAP_VEL));
    localparam logic signed [V_W-1:0] VelMax     = V_W'(MAX_FALL);
    localparam logic signed [V_W:0]   VelMaxW    = (V_W + 1)'(MAX_FALL);
    localparam logic [HW-1:0]         HoldInit   = HW'(DEAD_HOLD);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StFly  = 2'b01,
        StDead = 2'b10
    } state_e;

    state_e                state_q;
    logic [Y_W-1:0]        bird_y_q;
    logic signed [V_W-1:0] vel_q;
    logic                  alive_q;
    logic                  flap_ack_q;
    logic                  flap_pend_q;
    logic                  flap_pend_d;
    logic [HW-1:0]         hold_cnt_q;
    logic                  btn_q;

    logic                  rise;
    logic                  flap;
    logic signed [V_W:0]   vel_inc;
    logic signed [V_W-1:0] vel_n;
    logic signed [SW-1:0]  y_n;

    // A rise on a tick cycle is consumed by that tick; pending flaps never outlive a tick.
    always_comb begin
        rise        = flap_btn_i & ~btn_q;
        flap        = flap_pend_q | rise;
        flap_pend_d = frame_tick_i ? 1'b0 : (flap_pend_q | rise);
    end

    always_comb begin
        vel_inc = {vel_q[V_W-1], vel_q} + (V_W + 1)'(GRAVITY);
        if (flap) begin
            vel_n = VelFlap;
        end else if (vel_inc > VelMaxW) begin
            vel_n = VelMax;
        end else begin
            vel_n = vel_inc[V_W-1:0];
        end
        y_n = {2'b00, bird_y_q} + {{(SW - V_W){vel_n[V_W-1]}}, vel_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bird_y_q    <= YStart;
            vel_q       <= '0;
            alive_q     <= 1'b0;
            flap_ack_q  <= 1'b0;
            flap_pend_q <= 1'b0;
            hold_cnt_q  <= '0;
            btn_q       <= 1'b0;
        end else begin
            btn_q       <= flap_btn_i;
            flap_pend_q <= flap_pend_d;
            flap_ack_q  <= 1'b0;
            if (frame_tick_i) begin
                case (state_q)
                    StFly: begin
                        flap_ack_q <= flap;
                        if (y_n >= YMaxS) begin
                            state_q    <= StDead;
                            alive_q    <= 1'b0;
                            bird_y_q   <= YMaxY;
                            vel_q      <= '0;
                            hold_cnt_q <= HoldInit;
                        end else if (y_n[SW-1]) begin
                            bird_y_q <= '0;
                            vel_q    <= '0;
`ifdef CEILING_KILL_EN
                            state_q    <= StDead;
                            alive_q    <= 1'b0;
                            hold_cnt_q <= HoldInit;
`endif
                        end else begin
                            bird_y_q <= y_n[Y_W-1:0];
                            vel_q    <= vel_n;
                        end
                    end
                    StDead: begin
                        // Flaps are discarded until the hold window has fully expired.
                        if (hold_cnt_q != '0) begin
                            hold_cnt_q <= hold_cnt_q - HW'(1);
                        end else if (flap) begin
                            state_q  <= StIdle;
                            bird_y_q <= YStart;
                            vel_q    <= '0;
                        end
                    end
                    default: begin
                        if (flap) begin
                            state_q    <= StFly;
                            alive_q    <= 1'b1;
                            bird_y_q   <= YStartFlap;
                            vel_q      <= VelFlap;
                            flap_ack_q <= 1'b1;
                        end else begin
                            state_q  <= StIdle;
                            alive_q  <= 1'b0;
                            bird_y_q <= YStart;
                            vel_q    <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign bird_y_o   = bird_y_q;
    assign bird_vel_o = vel_q;
    assign state_o    = state_q;
    assign alive_o    = alive_q;
    assign flap_ack_o = flap_ack_q;

endmodule

// File: tb/tb_bird_physics.sv
// Directed, table-driven bench for bird_physics; honours CEILING_KILL_EN when defined.
module tb_bird_physics;

    localparam int StIdle = 0;
    localparam int StFly  = 1;
    localparam int StDead = 2;

    logic              clk;
    logic              rst_n;
    logic              flap_btn;
    logic              frame_tick;
    logic [9:0]        bird_y;
    logic signed [7:0] bird_vel;
    logic [1:0]        state;
    logic              alive;
    logic              flap_ack;

    bird_physics dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flap_btn_i   (flap_btn),
        .frame_tick_i (frame_tick),
        .bird_y_o     (bird_y),
        .bird_vel_o   (bird_vel),
        .state_o      (state),
        .alive_o      (alive),
        .flap_ack_o   (flap_ack)
    );

    typedef struct {
        bit flap;
        int y;
        int vel;
        int st;
        bit ack;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   ack_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (flap_ack) ack_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int y, input int vel, input int st,
                             input int ack);
        chk({tag, " y"}, int'(bird_y), y);
        chk({tag, " vel"}, int'(bird_vel), vel);
        chk({tag, " state"}, int'(state), st);
        chk({tag, " alive"}, int'(alive), (st == StFly) ? 1 : 0);
        chk({tag, " ack"}, int'(flap_ack), ack);
    endtask

    // One frame: optional 1-cycle button pulse, idle cycles, then the tick.
    task automatic frame(input bit flap);
        if (flap) begin
            flap_btn = 1'b1;
            step();
            flap_btn = 1'b0;
        end
        step();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic add(input bit flap, input int y, input int vel, input int st, input bit ack);
        vec_t v;
        v.flap = flap;
        v.y    = y;
        v.vel  = vel;
        v.st   = st;
        v.ack  = ack;
        tbl.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            frame(tbl[i].flap);
            check_out($sformatf("%s[%0d]", tag, i), tbl[i].y, tbl[i].vel, tbl[i].st,
                      int'(tbl[i].ack));
            step();
            chk($sformatf("%s[%0d] ack drop", tag, i), int'(flap_ack), 0);
        end
        tbl.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            frame_tick = i[0];
            flap_btn   = i[1];
            step();
        end
        frame_tick = 1'b0;
        flap_btn   = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    int ceil_st;

    initial begin
        rst_n      = 1'b0;
        flap_btn   = 1'b0;
        frame_tick = 1'b0;

        do_reset();
        check_out("reset", 240, 0, StIdle, 0);

        // Start, coast to apex, freefall to saturation, fall to floor, dead hold, restart.
        add(1, 232, -8, StFly, 1);
        add(0, 225, -7, StFly, 0);
        add(0, 219, -6, StFly, 0);
        add(0, 214, -5, StFly, 0);
        add(0, 210, -4, StFly, 0);
        add(0, 207, -3, StFly, 0);
        add(0, 205, -2, StFly, 0);
        add(0, 204, -1, StFly, 0);
        add(0, 204,  0, StFly, 0);
        add(0, 205,  1, StFly, 0);
        add(0, 207,  2, StFly, 0);
        add(0, 210,  3, StFly, 0);
        add(0, 214,  4, StFly, 0);
        add(0, 219,  5, StFly, 0);
        add(0, 225,  6, StFly, 0);
        add(0, 232,  7, StFly, 0);
        add(0, 240,  8, StFly, 0);
        add(0, 249,  9, StFly, 0);
        add(0, 259, 10, StFly, 0);
        add(0, 269, 10, StFly, 0);
        add(0, 279, 10, StFly, 0);
        for (int k = 1; k <= 18; k++) add(0, 279 + 10 * k, 10, StFly, 0);
        add(0, 464, 0, StDead, 0);
        for (int k = 1; k <= 60; k++) add(1, 464, 0, StDead, 0);
        add(1, 240, 0, StIdle, 0);
        add(0, 240, 0, StIdle, 0);
        add(1, 232, -8, StFly, 1);
        run_table("fall");

        // Button held across three ticks gives exactly one flap.
        do_reset();
        ack_cnt  = 0;
        flap_btn = 1'b1;
        step();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_out("held t1", 232, -8, StFly, 1);
        step();
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_out("held t2", 225, -7, StFly, 0);
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_out("held t3", 219, -6, StFly, 0);
        step();
        chk("held ack count", ack_cnt, 1);
        flap_btn = 1'b0;
        step();

        // Rise on the tick cycle itself is used by that tick.
        flap_btn   = 1'b1;
        frame_tick = 1'b1;
        step();
        flap_btn   = 1'b0;
        frame_tick = 1'b0;
        check_out("coincident", 211, -8, StFly, 1);

        // Two rises before one tick merge into a single flap.
        step();
        flap_btn = 1'b1;
        step();
        flap_btn = 1'b0;
        step();
        flap_btn = 1'b1;
        step();
        flap_btn = 1'b0;
        step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        check_out("merged", 203, -8, StFly, 1);
        frame(1'b0);
        check_out("merged next", 196, -7, StFly, 0);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async reset", 240, 0, StIdle, 0);
        step();
        rst_n = 1'b1;
        step();

        // Ceiling: climb to y=1, then a flap would take y negative.
`ifdef CEILING_KILL_EN
        ceil_st = StDead;
`else
        ceil_st = StFly;
`endif
        do_reset();
        add(1, 232, -8, StFly, 1);
        add(0, 225, -7, StFly, 0);
        for (int k = 1; k <= 28; k++) add(1, 225 - 8 * k, -8, StFly, 1);
        add(1, 0, 0, ceil_st, 1);
        if (ceil_st == StFly) add(0, 1, 1, StFly, 0);
        else add(0, 0, 0, StDead, 0);
        run_table("ceiling");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
